// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: two half adders plus a carry flop, one bit per clock, LSB first.
// Optional SERIAL_ADD_SUB_EN adds an i_sub port for two's-complement A-B.
module half_adder (
    input  logic i_x,
    input  logic i_y,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_x ^ i_y;
    assign o_c = i_x & i_y;
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             i_sub,
`endif
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry_out
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_shift_a;
    logic [WIDTH-1:0] r_shift_b;
    logic [WIDTH-1:1] r_shift_s;
    logic             r_c;
    logic [CW-1:0]    r_cnt;

    logic             w_s1, w_c1, w_s, w_c2, w_c_next;
    logic             w_accept, w_last;
    logic [WIDTH-1:0] w_s_next;
    logic [WIDTH-1:0] w_b_load;
    logic             w_c_load;

    half_adder u_ha1 (.i_x(r_shift_a[0]), .i_y(r_shift_b[0]), .o_s(w_s1), .o_c(w_c1));
    half_adder u_ha2 (.i_x(w_s1),         .i_y(r_c),          .o_s(w_s),  .o_c(w_c2));

    assign w_c_next = w_c1 | w_c2;
    assign w_accept = (r_state == S_IDLE) && i_start;
    assign w_last   = (r_state == S_RUN) && (r_cnt == LAST);
    // Result bits accumulate from the top; the oldest bit falls off the bottom on each shift.
    assign w_s_next = {w_s, r_shift_s};

`ifdef SERIAL_ADD_SUB_EN
    assign w_b_load = i_sub ? ~i_b : i_b;
    assign w_c_load = i_sub;
`else
    assign w_b_load = i_b;
    assign w_c_load = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next = S_RUN;
            S_RUN:   if (r_cnt == LAST) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_shift_a   <= '0;
            r_shift_b   <= '0;
            r_shift_s   <= '0;
            r_c         <= 1'b0;
            r_cnt       <= '0;
            o_sum       <= '0;
            o_carry_out <= 1'b0;
        end else if (w_accept) begin
            r_shift_a <= i_a;
            r_shift_b <= w_b_load;
            r_c       <= w_c_load;
            r_cnt     <= '0;
        end else if (r_state == S_RUN) begin
            r_shift_a <= {1'b0, r_shift_a[WIDTH-1:1]};
            r_shift_b <= {1'b0, r_shift_b[WIDTH-1:1]};
            r_shift_s <= w_s_next[WIDTH-1:1];
            r_c       <= w_c_next;
            r_cnt     <= r_cnt + CW'(1);
            if (w_last) begin
                o_sum       <= w_s_next;
                o_carry_out <= w_c_next;
            end
        end
    end

    assign o_busy = (r_state == S_RUN);
    assign o_done = (r_state == S_DONE);
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl (WIDTH=4); subtract cases run when SERIAL_ADD_SUB_EN is defined.
module tb_serial_add_ctrl;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
`ifdef SERIAL_ADD_SUB_EN
    logic         sub;
`endif
    logic         busy, done, carry;
    logic [W-1:0] sum;

    int checks = 0;
    int errors = 0;
    logic [W:0] sb[$];

    serial_add_ctrl #(.WIDTH(W)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_a(a), .i_b(b),
`ifdef SERIAL_ADD_SUB_EN
        .i_sub(sub),
`endif
        .o_busy(busy), .o_done(done), .o_sum(sum), .o_carry_out(carry)
    );

    always #5 clk = ~clk;

    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        logic [W:0] r;
        if (s) r = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
        else   r = {1'b0, x} + {1'b0, y};
        return r;
    endfunction

    // Drives one request and waits (bounded) for the done pulse; k counts negedges after the accept edge.
    task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic osub,
                         output int done_k, output int busy_n, output logic [W:0] res);
        @(negedge clk);
        a = oa; b = ob; start = 1'b1;
`ifdef SERIAL_ADD_SUB_EN
        sub = osub;
`else
        if (osub) $display("note: subtract requested without SERIAL_ADD_SUB_EN");
`endif
        @(posedge clk); #1;
        start = 1'b0;
        done_k = 0; busy_n = 0; res = 'x;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (done) begin
                done_k = k;
                res = {carry, sum};
                break;
            end
        end
    endtask

    task automatic check_op(input string name, input int done_k, input int busy_n, input logic [W:0] res);
        logic [W:0] exp;
        exp = sb.pop_front();
        checks++;
        if (done_k !== W + 1) begin
            errors++;
            $display("FAIL %s latency: done at k=%0d, required k=%0d", name, done_k, W + 1);
        end
        checks++;
        if (busy_n !== W) begin
            errors++;
            $display("FAIL %s busy cycles: got %0d, required %0d", name, busy_n, W);
        end
        checks++;
        if (res !== exp) begin
            errors++;
            $display("FAIL %s result: got carry=%0b sum=%0d, required carry=%0b sum=%0d",
                     name, res[W], res[W-1:0], exp[W], exp[W-1:0]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
`ifdef SERIAL_ADD_SUB_EN
        sub = 1'b0;
`endif
        #12;
        checks++;
        if ({busy, done, carry, sum} !== '0) begin
            errors++;
            $display("FAIL reset_state: busy=%0b done=%0b carry=%0b sum=%0d, required all 0", busy, done, carry, sum);
        end
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%0b done=%0b, required 0 0", busy, done);
        end
    endtask

    task automatic test_add();
        int dk, bn;
        logic [W:0] res;
        sb.push_back(model(4'd3, 4'd5, 1'b0));
        do_op(4'd3, 4'd5, 1'b0, dk, bn, res);
        check_op("add_3_5", dk, bn, res);
        sb.push_back(model(4'd15, 4'd1, 1'b0));
        do_op(4'd15, 4'd1, 1'b0, dk, bn, res);
        check_op("wrap_15_1", dk, bn, res);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({done, carry, sum} !== {1'b0, 1'b1, 4'd0}) begin
                errors++;
                $display("FAIL hold_after_done: done=%0b carry=%0b sum=%0d, required 0 1 0", done, carry, sum);
            end
        end
    endtask

    task automatic test_hold_during_run();
        int dk, bn;
        logic [W:0] res, exp;
        sb.push_back(model(4'd3, 4'd5, 1'b0));
        do_op(4'd3, 4'd5, 1'b0, dk, bn, res);
        check_op("add_3_5_again", dk, bn, res);
        @(negedge clk);
        a = 4'd6; b = 4'd7; start = 1'b1;
        sb.push_back(model(4'd6, 4'd7, 1'b0));
        @(posedge clk); #1; start = 1'b0;
        dk = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (done) begin
                dk = k;
                exp = sb.pop_front();
                checks++;
                if ({carry, sum} !== exp) begin
                    errors++;
                    $display("FAIL add_6_7 result: got %0d, required %0d", {carry, sum}, exp);
                end
                break;
            end
            checks++;
            if ({carry, sum} !== 5'd8) begin
                errors++;
                $display("FAIL sum_stable_in_run: got %0d at k=%0d, required 8", {carry, sum}, k);
            end
        end
        checks++;
        if (dk !== W + 1) begin
            errors++;
            $display("FAIL add_6_7 latency: done at k=%0d, required %0d", dk, W + 1);
        end
    endtask

    task automatic test_start_held();
        logic [W:0] exp;
        int ndone;
        ndone = 0;
        @(negedge clk);
        a = 4'd1; b = 4'd1; start = 1'b1;
        sb.push_back(model(4'd1, 4'd1, 1'b0));
        @(posedge clk);
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (k == 2) a = 4'd7;
            if (done) begin
                ndone++;
                exp = sb.pop_front();
                checks++;
                if ({carry, sum} !== exp) begin
                    errors++;
                    $display("FAIL held_start result %0d: got %0d, required %0d", ndone, {carry, sum}, exp);
                end
            end
            if (k == 5 || k == 11) begin
                checks++;
                if (done !== 1'b1) begin
                    errors++;
                    $display("FAIL held_start done at k=%0d: got %0b, required 1", k, done);
                end
            end
            if (k == 6) begin
                checks++;
                if ({busy, done} !== 2'b00) begin
                    errors++;
                    $display("FAIL held_start idle gap: busy=%0b done=%0b, required 0 0", busy, done);
                end
                sb.push_back(model(4'd7, 4'd1, 1'b0));
            end
            if (k == 7) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL held_start reaccept at E0+6: busy=%0b, required 1", busy);
                end
                start = 1'b0;
            end
        end
        checks++;
        if (ndone !== 2) begin
            errors++;
            $display("FAIL held_start done count: got %0d, required 2", ndone);
        end
    endtask

    task automatic test_reset_mid_run();
        int dk, bn;
        logic [W:0] res;
        @(negedge clk);
        a = 4'd1; b = 4'd2; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, carry, sum} !== '0) begin
            errors++;
            $display("FAIL async_reset_mid_run: busy=%0b done=%0b carry=%0b sum=%0d, required all 0", busy, done, carry, sum);
        end
        @(negedge clk); rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if ({busy, done, sum} !== '0) begin
                errors++;
                $display("FAIL aborted_op_quiet: busy=%0b done=%0b sum=%0d, required 0", busy, done, sum);
            end
        end
        sb.push_back(model(4'd2, 4'd2, 1'b0));
        do_op(4'd2, 4'd2, 1'b0, dk, bn, res);
        check_op("add_2_2_after_reset", dk, bn, res);
    endtask

`ifdef SERIAL_ADD_SUB_EN
    task automatic test_sub();
        int dk, bn;
        logic [W:0] res;
        sb.push_back(5'b1_0010);
        do_op(4'd5, 4'd3, 1'b1, dk, bn, res);
        check_op("sub_5_3", dk, bn, res);
        sb.push_back(5'b0_1110);
        do_op(4'd3, 4'd5, 1'b1, dk, bn, res);
        check_op("sub_3_5", dk, bn, res);
    endtask
`endif

    task automatic test_back_to_back();
        int dk, bn;
        logic [W:0] res;
        logic [W-1:0] ra, rb;
        logic rs;
        for (int i = 0; i < 10; i++) begin
            ra = W'($urandom_range(0, 15));
            rb = W'($urandom_range(0, 15));
`ifdef SERIAL_ADD_SUB_EN
            rs = 1'($urandom_range(0, 1));
`else
            rs = 1'b0;
`endif
            sb.push_back(model(ra, rb, rs));
            do_op(ra, rb, rs, dk, bn, res);
            check_op("back_to_back", dk, bn, res);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_hold_during_run();
        test_start_held();
        test_reset_mid_run();
`ifdef SERIAL_ADD_SUB_EN
        test_sub();
`endif
        test_back_to_back();
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1, "timeout");
    end
endmodule
